// File: rtl/secuenciador_cs_campos.sv
// Registered chip-select sequencer: selects one field of one register group at a
// time, steps fields with next/previous pulses, and locks out after an idle timeout.
module secuenciador_cs_campos #(
  parameter int unsigned N_GRUPOS       = 3,
  parameter int unsigned N_CAMPOS       = 3,
  parameter int unsigned TIMEOUT_CICLOS = 100000000,
  localparam int unsigned WF  = $clog2(N_GRUPOS + 1),
  localparam int unsigned WC  = (N_CAMPOS > 2) ? $clog2(N_CAMPOS) : 1,
  localparam int unsigned NCS = N_GRUPOS * N_CAMPOS
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [WF-1:0]  funcion_conf,
  input  logic           btn_sig,
  input  logic           btn_ant,
  input  logic           actividad,
  output logic [NCS-1:0] cs,
  output logic [WF-1:0]  grupo_activo,
  output logic [WC-1:0]  campo_activo,
  output logic           config_activa,
  output logic           fin_config
);

  localparam int unsigned WT = (TIMEOUT_CICLOS > 2) ? $clog2(TIMEOUT_CICLOS) : 1;

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    EDITA   = 2'd1,
    BLOQUEO = 2'd2
  } estado_t;

  estado_t        r_estado, w_estado_next;
  logic [WF-1:0]  r_grupo, w_grupo_next;
  logic [WC-1:0]  r_campo, w_campo_next;
  logic [WT-1:0]  r_cnt, w_cnt_next;
  logic [NCS-1:0] r_cs, w_cs_next;
  logic           r_config, r_fin, w_fin_next;
  logic           w_valido, w_evento;

  // Next state, next field/group and idle counter, with exits ranked by priority
  always_comb begin
    w_estado_next = r_estado;
    w_grupo_next  = r_grupo;
    w_campo_next  = r_campo;
    w_cnt_next    = r_cnt;
    w_fin_next    = 1'b0;
    w_cs_next     = '0;
    w_valido      = (funcion_conf != '0) && (funcion_conf <= WF'(N_GRUPOS));
    w_evento      = btn_sig | btn_ant | actividad;

    case (r_estado)
      REPOSO: begin
        if (w_valido) begin
          w_estado_next = EDITA;
          w_grupo_next  = funcion_conf;
          w_campo_next  = '0;
          w_cnt_next    = '0;
        end
      end
      EDITA: begin
        if (!w_valido) begin
          w_estado_next = REPOSO;
          w_fin_next    = 1'b1;
          w_grupo_next  = '0;
          w_campo_next  = '0;
          w_cnt_next    = '0;
        end else if ((r_cnt == WT'(TIMEOUT_CICLOS - 1)) && !w_evento) begin
          w_estado_next = BLOQUEO;
          w_fin_next    = 1'b1;
          w_grupo_next  = '0;
          w_campo_next  = '0;
          w_cnt_next    = '0;
        end else if (funcion_conf != r_grupo) begin
          w_grupo_next  = funcion_conf;
          w_campo_next  = '0;
          w_cnt_next    = '0;
        end else begin
          if (btn_sig && !btn_ant) begin
            w_campo_next = (r_campo == WC'(N_CAMPOS - 1)) ? '0 : r_campo + WC'(1);
          end else if (btn_ant && !btn_sig) begin
            w_campo_next = (r_campo == '0) ? WC'(N_CAMPOS - 1) : r_campo - WC'(1);
          end
          if (w_evento) begin
            w_cnt_next = '0;
          end else if (r_cnt != '1) begin
            w_cnt_next = r_cnt + WT'(1);
          end
        end
      end
      BLOQUEO: begin
        if (!w_valido) begin
          w_estado_next = REPOSO;
        end
      end
      default: begin
        w_estado_next = REPOSO;
        w_grupo_next  = '0;
        w_campo_next  = '0;
        w_cnt_next    = '0;
      end
    endcase

    // Chip select decoded from the next group/field so it lands in the same edge
    if (w_estado_next == EDITA) begin
      w_cs_next = NCS'(1) << ((32'(w_grupo_next) - 32'd1) * N_CAMPOS + 32'(w_campo_next));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_estado <= REPOSO;
      r_grupo  <= '0;
      r_campo  <= '0;
      r_cnt    <= '0;
      r_cs     <= '0;
      r_config <= 1'b0;
      r_fin    <= 1'b0;
    end else begin
      r_estado <= w_estado_next;
      r_grupo  <= w_grupo_next;
      r_campo  <= w_campo_next;
      r_cnt    <= w_cnt_next;
      r_cs     <= w_cs_next;
      r_config <= (w_estado_next == EDITA);
      r_fin    <= w_fin_next;
    end
  end

  assign cs            = r_cs;
  assign grupo_activo  = r_grupo;
  assign campo_activo  = r_campo;
  assign config_activa = r_config;
  assign fin_config    = r_fin;

endmodule

// File: tb/tb_secuenciador_cs_campos.sv
// Bench for secuenciador_cs_campos: directed plan plus random traffic, checked each
// cycle against a cycle-stamp based model of the field selection rules.
module tb_secuenciador_cs_campos;

  localparam int NG = 3;
  localparam int NC = 3;
  localparam int T  = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] fc, fc2;
  logic       btn_sig, btn_ant, act;
  logic [8:0] cs;
  logic [1:0] grupo, campo;
  logic       config_a, fin;
  logic [3:0] cs2;
  logic [1:0] grupo2;
  logic [0:0] campo2;
  logic       config2, fin2;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  // Model: mode 0 idle, 1 editing, 2 locked; timeout measured from last clear stamp
  int  m_mode = 0, m_grp = 0, m_campo = 0;
  longint m_cyc = 0, m_last = 0;
  bit  m_fin = 1'b0;
  bit  m_ok, m_any;
  logic [8:0] exp_cs;

  secuenciador_cs_campos #(.N_GRUPOS(NG), .N_CAMPOS(NC), .TIMEOUT_CICLOS(T)) u_dut (
    .clk(clk), .reset(reset), .funcion_conf(fc), .btn_sig(btn_sig), .btn_ant(btn_ant),
    .actividad(act), .cs(cs), .grupo_activo(grupo), .campo_activo(campo),
    .config_activa(config_a), .fin_config(fin)
  );

  secuenciador_cs_campos #(.N_GRUPOS(2), .N_CAMPOS(2), .TIMEOUT_CICLOS(4)) u_dut2 (
    .clk(clk), .reset(reset), .funcion_conf(fc2), .btn_sig(1'b0), .btn_ant(1'b0),
    .actividad(1'b0), .cs(cs2), .grupo_activo(grupo2), .campo_activo(campo2),
    .config_activa(config2), .fin_config(fin2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    m_cyc++;
    m_ok  = (fc >= 1) && (int'(fc) <= NG);
    m_any = btn_sig | btn_ant | act;
    m_fin = 1'b0;
    if (reset) begin
      m_mode = 0; m_grp = 0; m_campo = 0;
    end else begin
      case (m_mode)
        0: if (m_ok) begin
             m_mode = 1; m_grp = int'(fc); m_campo = 0; m_last = m_cyc;
           end
        1: if (!m_ok) begin
             m_mode = 0; m_fin = 1'b1;
           end else if (!m_any && (m_cyc - m_last == longint'(T))) begin
             m_mode = 2; m_fin = 1'b1;
           end else if (int'(fc) != m_grp) begin
             m_grp = int'(fc); m_campo = 0; m_last = m_cyc;
           end else begin
             if (btn_sig && !btn_ant) m_campo = (m_campo + 1) % NC;
             if (btn_ant && !btn_sig) m_campo = (m_campo + NC - 1) % NC;
             if (m_any) m_last = m_cyc;
           end
        default: if (!m_ok) m_mode = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      exp_cs = (m_mode == 1) ? (9'd1 << ((m_grp - 1) * NC + m_campo)) : 9'd0;
      chk("cs", 32'(cs), 32'(exp_cs));
      chk("grupo", 32'(grupo), (m_mode == 1) ? 32'(m_grp) : 32'd0);
      chk("campo", 32'(campo), (m_mode == 1) ? 32'(m_campo) : 32'd0);
      chk("config", 32'(config_a), (m_mode == 1) ? 32'd1 : 32'd0);
      chk("fin", 32'(fin), 32'(m_fin));
    end
  end

  task automatic cyc(input logic [1:0] f, input logic s, input logic a, input logic ac);
    fc = f; btn_sig = s; btn_ant = a; act = ac;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [2:0] seq_sig [4];
    seq_sig[0] = 3'd1; seq_sig[1] = 3'd2; seq_sig[2] = 3'd0; seq_sig[3] = 3'd1;
    reset = 1'b1; fc2 = 2'd3;
    repeat (3) cyc(2'd2, 1'b0, 1'b0, 1'b0);
    cmp_en = 1'b1;
    chk("rst_cs", 32'(cs), 32'd0);
    chk("rst_cfg", 32'(config_a), 32'd0);
    chk("rst_fin", 32'(fin), 32'd0);

    reset = 1'b0;
    cyc(2'd2, 1'b0, 1'b0, 1'b0);
    chk("entry_cs", 32'(cs), 32'(9'b000_001_000));
    chk("entry_grupo", 32'(grupo), 32'd2);
    chk("entry_campo", 32'(campo), 32'd0);
    chk("inv_cfg2", 32'(config2), 32'd0);
    chk("inv_cs2", 32'(cs2), 32'd0);

    fc2 = 2'd2;
    cyc(2'd1, 1'b0, 1'b0, 1'b0);
    chk("grp1_cs", 32'(cs), 32'(9'b000_000_001));
    chk("g2_cs2", 32'(cs2), 32'(4'b0100));
    fc2 = 2'd3;
    for (int i = 0; i < 4; i++) begin
      cyc(2'd1, 1'b1, 1'b0, 1'b0);
      chk("sig_campo", 32'(campo), 32'(seq_sig[i]));
      if (i == 0) begin
        chk("inv_exit_cfg2", 32'(config2), 32'd0);
        chk("inv_exit_fin2", 32'(fin2), 32'd1);
      end
    end
    cyc(2'd1, 1'b0, 1'b1, 1'b0);
    chk("ant_campo0", 32'(campo), 32'd0);
    cyc(2'd1, 1'b0, 1'b1, 1'b0);
    chk("ant_wrap", 32'(campo), 32'd2);
    cyc(2'd1, 1'b1, 1'b1, 1'b0);
    chk("both_campo", 32'(campo), 32'd2);

    cyc(2'd3, 1'b0, 1'b0, 1'b0);
    cyc(2'd3, 1'b1, 1'b0, 1'b0);
    cyc(2'd3, 1'b1, 1'b0, 1'b0);
    chk("g3c2_cs", 32'(cs), 32'(9'b100_000_000));
    cyc(2'd1, 1'b0, 1'b0, 1'b0);
    chk("switch_cs", 32'(cs), 32'(9'b000_000_001));
    chk("switch_campo", 32'(campo), 32'd0);
    chk("switch_fin", 32'(fin), 32'd0);

    repeat (T - 1) cyc(2'd1, 1'b0, 1'b0, 1'b0);
    chk("pre_to_cfg", 32'(config_a), 32'd1);
    cyc(2'd1, 1'b0, 1'b0, 1'b0);
    chk("to_cfg", 32'(config_a), 32'd0);
    chk("to_fin", 32'(fin), 32'd1);
    chk("to_cs", 32'(cs), 32'd0);
    cyc(2'd1, 1'b0, 1'b0, 1'b0);
    chk("lock_fin", 32'(fin), 32'd0);
    chk("lock_cs", 32'(cs), 32'd0);
    cyc(2'd0, 1'b0, 1'b0, 1'b0);
    chk("unlock_fin", 32'(fin), 32'd0);
    cyc(2'd1, 1'b0, 1'b0, 1'b0);
    chk("reenter_cs", 32'(cs), 32'(9'b000_000_001));

    for (int i = 0; i < 100; i++) cyc(2'd1, 1'b0, 1'b0, (i % 10) == 9);
    chk("act_keep", 32'(config_a), 32'd1);
    repeat (T - 1) cyc(2'd1, 1'b0, 1'b0, 1'b0);
    cyc(2'd1, 1'b0, 1'b0, 1'b1);
    chk("act_edge_keep", 32'(config_a), 32'd1);
    chk("act_edge_fin", 32'(fin), 32'd0);

    reset = 1'b1;
    cyc(2'd1, 1'b0, 1'b0, 1'b0);
    chk("midrst_cs", 32'(cs), 32'd0);
    chk("midrst_fin", 32'(fin), 32'd0);
    reset = 1'b0;

    fc = 2'd1;
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] f;
      int bd;
      f  = fc;
      bd = (i < 1500) ? 5 : 60;
      if ($urandom_range(39) == 0) f = 2'($urandom_range(3));
      reset = ($urandom_range(299) == 0);
      cyc(f, $urandom_range(bd) == 0, $urandom_range(bd) == 0, $urandom_range(bd * 2) == 0);
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
